// File: rtl/cam_clk_ctrl_if.sv
// Control bundle between the capture controller and cam_clk_ctrl.
// Carries the power request, the divider load port and the ready status.
interface cam_clk_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             pwr_req;
    logic [DIV_W-1:0] div_cfg;
    logic             div_load;
    logic             ready;

    modport master (output pwr_req, output div_cfg, output div_load, input ready);
    modport slave  (input pwr_req, input div_cfg, input div_load, output ready);
endinterface

// File: rtl/cam_clk_ctrl.sv
// Camera xclk divider, power-down/reset sequencer and pixel-clock resync into clk.
// Build option: define CAM_PCLK_SYNC_EN for the SYNC_STAGES-deep p_clock_c synchronizer and pclk_rise.
module cam_clk_ctrl #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 5,
    parameter int SETTLE_CYC   = 16,
    parameter int RST_HOLD_CYC = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    cam_clk_ctrl_if.slave ctrl_if,
    input  logic          cam_ot,
    input  logic          p_clock_c,
    output logic          xclk,
    output logic          cam_rst_n,
    output logic          cam_pwdn,
    output logic          p_clock,
    output logic          pclk_rise
);
    localparam int MAX_CYC = (SETTLE_CYC > RST_HOLD_CYC) ? SETTLE_CYC : RST_HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {S_OFF, S_PWR_UP, S_RST_HOLD, S_RUN} state_t;

    if (SYNC_STAGES < 2) begin : g_sync_stages_check
        $error("cam_clk_ctrl: SYNC_STAGES must be at least 2");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_state_cnt;
    logic             r_cam_pwdn;
    logic             r_cam_rst_n;
    logic             r_ready;
    logic             w_cam_pwdn_nxt;
    logic             w_cam_rst_n_nxt;
    logic             w_ready_nxt;

    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latch).
    always_comb begin
        w_state_nxt     = r_state;
        w_cam_pwdn_nxt  = 1'b0;
        w_cam_rst_n_nxt = 1'b1;
        w_ready_nxt     = 1'b0;
        if (!ctrl_if.pwr_req) begin
            w_state_nxt = S_OFF;
        end else begin
            case (r_state)
                S_OFF:      w_state_nxt = S_PWR_UP;
                S_PWR_UP:   if (r_state_cnt == CNT_W'(SETTLE_CYC - 1))   w_state_nxt = S_RST_HOLD;
                S_RST_HOLD: if (r_state_cnt == CNT_W'(RST_HOLD_CYC - 1)) w_state_nxt = S_RUN;
                default:    w_state_nxt = r_state;
            endcase
        end
        case (w_state_nxt)
            S_OFF: begin
                w_cam_pwdn_nxt  = 1'b1;
                w_cam_rst_n_nxt = 1'b0;
            end
            S_RST_HOLD: w_cam_rst_n_nxt = 1'b0;
            S_RUN:      w_ready_nxt     = 1'b1;
            default:    ;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_OFF;
            r_state_cnt <= '0;
            r_cam_pwdn  <= 1'b1;
            r_cam_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_state_cnt <= (w_state_nxt != r_state) ? '0 : r_state_cnt + 1'b1;
            r_cam_pwdn  <= w_cam_pwdn_nxt;
            r_cam_rst_n <= w_cam_rst_n_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_pending;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_xclk;
    logic             w_div_tc;
    logic [DIV_W-1:0] w_div_cfg_safe;

    assign w_div_tc       = (r_div_cnt == r_div_active - 1'b1);
    assign w_div_cfg_safe = (ctrl_if.div_cfg == '0) ? DIV_W'(1) : ctrl_if.div_cfg;

    // A new half-period only takes effect at a toggle, so no phase is ever cut short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_active  <= DIV_W'(DEFAULT_DIV);
            r_div_pending <= DIV_W'(DEFAULT_DIV);
            r_div_cnt     <= '0;
            r_xclk        <= 1'b0;
        end else begin
            if (ctrl_if.div_load) begin
                r_div_pending <= w_div_cfg_safe;
            end
            if (w_state_nxt == S_OFF) begin
                r_div_cnt <= '0;
                r_xclk    <= 1'b0;
            end else if (r_state != S_OFF && cam_ot) begin
                if (w_div_tc) begin
                    r_div_cnt    <= '0;
                    r_xclk       <= ~r_xclk;
                    r_div_active <= r_div_pending;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

    logic r_p_clock;

`ifdef CAM_PCLK_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pclk_rise;

    // The synchronizer keeps sampling while cam_ot is low; only the output stage freezes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_p_clock   <= 1'b0;
            r_pclk_rise <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], p_clock_c};
            r_pclk_rise <= cam_ot & r_sync[SYNC_STAGES-1] & ~r_p_clock;
            if (cam_ot) begin
                r_p_clock <= r_sync[SYNC_STAGES-1];
            end
        end
    end

    assign pclk_rise = r_pclk_rise;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_clock <= 1'b0;
        end else if (cam_ot) begin
            r_p_clock <= p_clock_c;
        end
    end

    assign pclk_rise = 1'b0;
`endif

    assign xclk          = r_xclk;
    assign cam_rst_n     = r_cam_rst_n;
    assign cam_pwdn      = r_cam_pwdn;
    assign p_clock       = r_p_clock;
    assign ctrl_if.ready = r_ready;
endmodule

// File: tb/tb_cam_clk_ctrl.sv
// Self-checking bench for cam_clk_ctrl: directed power/divider/freeze scenarios plus
// randomized traffic compared each cycle against a phase-level behavioural model.
module tb_cam_clk_ctrl;
    localparam int DIV_W        = 8;
    localparam int DEFAULT_DIV  = 5;
    localparam int SETTLE_CYC   = 16;
    localparam int RST_HOLD_CYC = 32;
    localparam int SYNC_STAGES  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic cam_ot;
    logic p_clock_c;
    logic xclk, cam_rst_n, cam_pwdn, p_clock, pclk_rise;

    cam_clk_ctrl_if #(.DIV_W(DIV_W)) u_if ();

    cam_clk_ctrl #(
        .DIV_W        (DIV_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .SETTLE_CYC   (SETTLE_CYC),
        .RST_HOLD_CYC (RST_HOLD_CYC),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_if   (u_if.slave),
        .cam_ot    (cam_ot),
        .p_clock_c (p_clock_c),
        .xclk      (xclk),
        .cam_rst_n (cam_rst_n),
        .cam_pwdn  (cam_pwdn),
        .p_clock   (p_clock),
        .pclk_rise (pclk_rise)
    );

    always #2 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks the power phase, time spent in it, and the cycles left
    // in the current xclk half-period.
    typedef enum {M_OFF, M_PWR_UP, M_RST_HOLD, M_RUN} m_phase_e;
    m_phase_e m_st   = M_OFF;
    m_phase_e m_nx;
    int       m_dwell   = 0;
    int       m_left    = DEFAULT_DIV;
    int       m_active  = DEFAULT_DIV;
    int       m_pending = DEFAULT_DIV;
    bit       m_xclk    = 1'b0;
    bit       m_pclk    = 1'b0;
    bit       m_rise    = 1'b0;
`ifdef CAM_PCLK_SYNC_EN
    bit       m_hist [SYNC_STAGES];
    bit       m_seen;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st      = M_OFF;
            m_dwell   = 0;
            m_xclk    = 1'b0;
            m_active  = DEFAULT_DIV;
            m_pending = DEFAULT_DIV;
            m_left    = DEFAULT_DIV;
            m_pclk    = 1'b0;
            m_rise    = 1'b0;
`ifdef CAM_PCLK_SYNC_EN
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
`endif
        end else begin
            m_nx = m_st;
            if (!u_if.pwr_req) begin
                m_nx = M_OFF;
            end else begin
                case (m_st)
                    M_OFF:      m_nx = M_PWR_UP;
                    M_PWR_UP:   if (m_dwell + 1 >= SETTLE_CYC)   m_nx = M_RST_HOLD;
                    M_RST_HOLD: if (m_dwell + 1 >= RST_HOLD_CYC) m_nx = M_RUN;
                    default:    ;
                endcase
            end

            if (m_nx == M_OFF) begin
                m_xclk = 1'b0;
                m_left = m_active;
            end else if (m_st != M_OFF && cam_ot) begin
                m_left--;
                if (m_left == 0) begin
                    m_xclk   = !m_xclk;
                    m_active = m_pending;
                    m_left   = m_active;
                end
            end
            if (u_if.div_load) m_pending = (u_if.div_cfg == 0) ? 1 : int'(u_if.div_cfg);

`ifdef CAM_PCLK_SYNC_EN
            m_seen = m_hist[SYNC_STAGES-1];
            m_rise = cam_ot && m_seen && !m_pclk;
            if (cam_ot) m_pclk = m_seen;
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = p_clock_c;
`else
            m_rise = 1'b0;
            if (cam_ot) m_pclk = p_clock_c;
`endif

            m_dwell = (m_nx != m_st) ? 0 : m_dwell + 1;
            m_st    = m_nx;
        end
    end

    task automatic compare_all();
        check("xclk",      xclk,       m_xclk);
        check("cam_pwdn",  cam_pwdn,   m_st == M_OFF);
        check("cam_rst_n", cam_rst_n,  m_st == M_PWR_UP || m_st == M_RUN);
        check("ready",     u_if.ready, m_st == M_RUN);
        check("p_clock",   p_clock,    m_pclk);
        check("pclk_rise", pclk_rise,  m_rise);
    endtask

    // Pixel clock source: 12.5 MHz square wave (toggle every 10 clk) or random bits.
    int pc_div  = 0;
    bit pc_rand = 1'b0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (pc_rand) begin
            p_clock_c = 1'($urandom_range(0, 1));
        end else begin
            pc_div++;
            if (pc_div == 10) begin
                pc_div    = 0;
                p_clock_c = ~p_clock_c;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_xclk"},      xclk,       0);
        check({tag, "_cam_pwdn"},  cam_pwdn,   1);
        check({tag, "_cam_rst_n"}, cam_rst_n,  0);
        check({tag, "_p_clock"},   p_clock,    0);
        check({tag, "_pclk_rise"}, pclk_rise,  0);
        check({tag, "_ready"},     u_if.ready, 0);
    endtask

    // Expects pwr_req=1 to be sampled at the next edge (+1).
    task automatic power_up_seq(input string tag);
        for (int n = 1; n <= SETTLE_CYC + RST_HOLD_CYC + 1; n++) begin
            tick();
            if (n == 1) check({tag, "_pwdn_fall"}, cam_pwdn, 0);
            if (n == SETTLE_CYC) check({tag, "_rst_still_high"}, cam_rst_n, 1);
            if (n == SETTLE_CYC + 1) check({tag, "_rst_fall"}, cam_rst_n, 0);
            if (n == SETTLE_CYC + RST_HOLD_CYC) begin
                check({tag, "_rst_held"}, cam_rst_n, 0);
                check({tag, "_not_ready"}, u_if.ready, 0);
            end
            if (n == SETTLE_CYC + RST_HOLD_CYC + 1) begin
                check({tag, "_rst_release"}, cam_rst_n, 1);
                check({tag, "_ready"}, u_if.ready, 1);
            end
        end
    endtask

    task automatic wait_toggle(output int cyc);
        logic v;
        v   = xclk;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (xclk == v && cyc < 200);
        if (cyc >= 200) check("xclk_toggle_timeout", xclk != v, 1);
    endtask

    task automatic load_div(input int cfg);
        u_if.div_cfg  = DIV_W'(cfg);
        u_if.div_load = 1'b1;
        tick();
        u_if.div_load = 1'b0;
    endtask

    int c;
    int rises;

    initial begin
        rst_n         = 1'b0;
        cam_ot        = 1'b1;
        p_clock_c     = 1'b0;
        u_if.pwr_req  = 1'b1;
        u_if.div_cfg  = '0;
        u_if.div_load = 1'b0;

        repeat (3) tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        power_up_seq("pwrup");

        // Default divider in RUN: 20 half-periods of 5 cycles.
        wait_toggle(c);
        for (int i = 0; i < 20; i++) begin
            wait_toggle(c);
            check("run_half_period", c, DEFAULT_DIV);
        end

        // Load 3 mid-phase: current phase still 5, then 3.
        wait_toggle(c);
        tick();
        tick();
        load_div(3);
        wait_toggle(c);
        check("div_old_phase", c + 3, 5);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(c);
            check("div3_phase", c, 3);
        end

        // Load 0 behaves as 1: period 2.
        load_div(0);
        wait_toggle(c);
        check("div0_old_phase", c + 1, 3);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(c);
            check("div0_phase", c, 1);
        end
        load_div(DEFAULT_DIV);
        wait_toggle(c);

        // Freeze with xclk high: remaining high time resumes where it stopped.
        wait_toggle(c);
        if (xclk == 1'b0) wait_toggle(c);
        tick();
        tick();
        cam_ot = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("freeze_xclk_high", xclk, 1);
        end
        cam_ot = 1'b1;
        wait_toggle(c);
        check("freeze_resume_left", c, DEFAULT_DIV - 2);

        // One pclk_rise per 20-cycle p_clock_c period.
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pclk_rise) rises++;
        end
`ifdef CAM_PCLK_SYNC_EN
        check("pclk_rise_count", rises, 10);
`else
        check("pclk_rise_count", rises, 0);
`endif

        // Drop pwr_req in RST_HOLD, then a full restart.
        u_if.pwr_req = 1'b0;
        tick();
        tick();
        u_if.pwr_req = 1'b1;
        for (int i = 0; i < SETTLE_CYC + 4; i++) tick();
        check("in_rst_hold", cam_rst_n, 0);
        u_if.pwr_req = 1'b0;
        tick();
        check("drop_pwdn",  cam_pwdn,   1);
        check("drop_rst_n", cam_rst_n,  0);
        check("drop_xclk",  xclk,       0);
        check("drop_ready", u_if.ready, 0);
        u_if.pwr_req = 1'b1;
        power_up_seq("restart");

        // Reset taken mid-RUN.
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        check_reset_values("midrst");
        rst_n = 1'b1;
        power_up_seq("after_midrst");

        // Randomized traffic against the model.
        pc_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if (u_if.pwr_req) begin
                if ($urandom_range(0, 149) == 0) u_if.pwr_req = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                u_if.pwr_req = 1'b1;
            end
            cam_ot        = ($urandom_range(0, 7) != 0);
            u_if.div_load = ($urandom_range(0, 19) == 0);
            u_if.div_cfg  = DIV_W'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
